// File: rtl/reset_sequencer.sv
// Holds the core in reset until PLL lock has been stable and a hold interval has elapsed.
// Optional lock-loss event counter built when RESET_SEQUENCER_LOSS_CNT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | core in reset, waiting for synchronised lock
// STABLE    | lock seen, counting LOCK_STABLE_CYCLES of continuous lock
// HOLD      | lock declared stable, counting RESET_HOLD_CYCLES
// RUN       | core released; any lock loss returns to WAIT_LOCK
module reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       pll_locked,
    output logic       rst_out_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [15:0] STABLE_TC = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] HOLD_TC   = 16'(RESET_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 cur_state;
    state_t                 nxt_state;
    logic [15:0]            cnt;
    logic [15:0]            cnt_nxt;
    logic                   run_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_state <= WAIT_LOCK;
            cnt       <= '0;
            run_q     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
            run_q     <= (nxt_state == RUN);
        end
    end

    // Lock loss is tested first so it wins over a terminal count in the same cycle.
    always_comb begin
        nxt_state = cur_state;
        cnt_nxt   = cnt;
        case (cur_state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    nxt_state = STABLE;
                    cnt_nxt   = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    nxt_state = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_TC) begin
                    nxt_state = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    nxt_state = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_TC) begin
                    nxt_state = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    nxt_state = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                nxt_state = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rst_out_n = run_q;
    assign ready     = run_q;
    assign state     = cur_state;

`ifdef RESET_SEQUENCER_LOSS_CNT_EN
    logic [7:0] loss_q;

    // Saturating; only the board reset clears it so history survives re-lock.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            loss_q <= '0;
        end else if ((cur_state == RUN) && (nxt_state == WAIT_LOCK) && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer with SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4.
module tb_reset_sequencer;

    localparam int S = 2;
    localparam int L = 8;
    localparam int H = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       pll_locked;
    logic       rst_out_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_cnt;

    reset_sequencer #(
        .SYNC_STAGES       (S),
        .LOCK_STABLE_CYCLES(L),
        .RESET_HOLD_CYCLES (H)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .pll_locked   (pll_locked),
        .rst_out_n    (rst_out_n),
        .ready        (ready),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #31 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] st;
        logic       rst;
        logic       rdy;
        logic [7:0] llc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_llc;

    // rel = edge number counted from the edge that first samples pll_locked high (1-based).
    function automatic logic [1:0] seq_state(int rel);
        if (rel < S + 1)         return 2'd0;
        if (rel < S + 1 + L)     return 2'd1;
        if (rel < S + 1 + L + H) return 2'd2;
        return 2'd3;
    endfunction

    function automatic exp_t exp_at(int rel);
        exp_t e;
        e.st  = seq_state(rel);
        e.rst = (e.st == 2'd3);
        e.rdy = (e.st == 2'd3);
        e.llc = exp_llc;
        return e;
    endfunction

    function automatic void bump_llc();
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
        if (exp_llc != 8'hFF) exp_llc = exp_llc + 8'd1;
`endif
    endfunction

    task automatic test_reset();
        exp_t e;
        exp_t obs;
        RST_N      = 1'b0;
        pll_locked = 1'b1;
        exp_llc    = 8'h00;
        for (int k = 0; k < 4; k++) sb.push_back('0);
        for (int k = 0; k < 4; k++) begin
            pll_locked = k[0];
            @(negedge CLK);
            e   = sb.pop_front();
            obs = {state, rst_out_n, ready, lock_loss_cnt};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", k, obs, e);
            end
        end
        pll_locked = 1'b1;
    endtask

    task automatic test_release();
        exp_t e;
        exp_t obs;
        for (int k = 1; k <= 18; k++) sb.push_back(exp_at(k));
        RST_N = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge CLK);
            e   = sb.pop_front();
            obs = {state, rst_out_n, ready, lock_loss_cnt};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL release edge %0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    // Lock drops for one cycle at STABLE cnt=5; the sequence must restart, not resume.
    task automatic test_chatter();
        exp_t e;
        exp_t obs;
        RST_N = 1'b0;
        @(negedge CLK);
        for (int k = 1; k <= 27; k++) sb.push_back((k <= 10) ? exp_at(k) : exp_at(k - 9));
        RST_N      = 1'b1;
        pll_locked = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            if (k == 9)  pll_locked = 1'b0;
            if (k == 10) pll_locked = 1'b1;
            @(negedge CLK);
            e   = sb.pop_front();
            obs = {state, rst_out_n, ready, lock_loss_cnt};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL chatter edge %0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    task automatic test_loss();
        exp_t e;
        exp_t obs;
        sb.push_back({2'd3, 1'b1, 1'b1, exp_llc});
        sb.push_back({2'd3, 1'b1, 1'b1, exp_llc});
        bump_llc();
        for (int k = 3; k <= 5; k++) sb.push_back({2'd0, 1'b0, 1'b0, exp_llc});
        pll_locked = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            e   = sb.pop_front();
            obs = {state, rst_out_n, ready, lock_loss_cnt};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL loss edge %0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        exp_t obs;
        for (int k = 1; k <= 12; k++) sb.push_back(exp_at(k));
        pll_locked = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            e   = sb.pop_front();
            obs = {state, rst_out_n, ready, lock_loss_cnt};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL prehold edge %0d: got %h expected %h", k, obs, e);
            end
        end
        RST_N   = 1'b0;
        exp_llc = 8'h00;
        #1;
        obs = {state, rst_out_n, ready, lock_loss_cnt};
        checks++;
        if (obs !== exp_t'(0)) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs, exp_t'(0));
        end
        @(negedge CLK);
        for (int k = 1; k <= 16; k++) sb.push_back(exp_at(k));
        RST_N = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            e   = sb.pop_front();
            obs = {state, rst_out_n, ready, lock_loss_cnt};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL rerun edge %0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        exp_t obs;
        logic [7:0] final_llc;
        for (int n = 0; n < 300; n++) begin
            bump_llc();
            sb.push_back({2'd0, 1'b0, 1'b0, exp_llc});
            pll_locked = 1'b0;
            repeat (S + 1) @(negedge CLK);
            e   = sb.pop_front();
            obs = {state, rst_out_n, ready, lock_loss_cnt};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sat_loss iter %0d: got %h expected %h", n, obs, e);
            end
            sb.push_back({2'd3, 1'b1, 1'b1, exp_llc});
            pll_locked = 1'b1;
            repeat (S + 1 + L + H) @(negedge CLK);
            e   = sb.pop_front();
            obs = {state, rst_out_n, ready, lock_loss_cnt};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sat_run iter %0d: got %h expected %h", n, obs, e);
            end
        end
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
        final_llc = 8'hFF;
`else
        final_llc = 8'h00;
`endif
        checks++;
        if (lock_loss_cnt !== final_llc) begin
            errors++;
            $display("FAIL sat_final: got %h expected %h", lock_loss_cnt, final_llc);
        end
    endtask

    initial begin
        RST_N      = 1'b0;
        pll_locked = 1'b0;
        exp_llc    = 8'h00;
        @(negedge CLK);
        test_reset();
        test_release();
        test_chatter();
        test_loss();
        test_reset_mid_hold();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
